fifo_umbrales: RTL and testbench

FIFO_UMBRALES -- requirements
Module: fifo_umbrales

---
 rtl/fifo_pkg.sv | 10 +
 rtl/fifo_mem.sv | 20 ++
 rtl/fifo_umbrales.sv | 73 +++++++
 tb/tb_fifo_umbrales.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults, pointer-width derivation and reset values for fifo_umbrales.
package fifo_pkg;
   localparam int DATA_W_DEF = 10;
   localparam int DEPTH_DEF = 8;
   localparam logic RST_VALID = 1'b0;
   localparam logic RST_ERR = 1'b0;
   function automatic int addr_w(input int depth);
      return $clog2(depth);
   endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DATA_W register array, one synchronous write port, one asynchronous read port.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int ADDR_W = addr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_umbrales.sv
// fifo_umbrales: synchronous FIFO with programmable almost-full/almost-empty thresholds.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module fifo_umbrales
   import fifo_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int ADDR_W = addr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] data_in,
   input  logic              rd_en,
   input  logic              continuar,
   input  logic [ADDR_W:0]   umbral_af,
   input  logic [ADDR_W:0]   umbral_ae,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              full,
   output logic              almost_full,
   output logic              empty,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count,
   output logic              err_overflow,
   output logic              err_underflow
);
   logic [ADDR_W-1:0] wptr, rptr;
   logic [DATA_W-1:0] rdata;
   logic              push, pop;
   assign full = count == (ADDR_W+1)'(DEPTH);
   assign empty = count == '0;
   assign almost_full = count >= umbral_af;
   assign almost_empty = count <= umbral_ae;
   // pop is resolved first so a full FIFO can still accept a push in the same cycle
   assign pop = rd_en & continuar & ~empty;
   assign push = wr_en & (~full | pop);
   fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
      .clk(clk),
      .we(push),
      .waddr(wptr),
      .wdata(data_in),
      .raddr(rptr),
      .rdata(rdata)
   );
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         wptr <= '0;
         rptr <= '0;
         count <= '0;
         data_out <= '0;
         valid_out <= RST_VALID;
      end else begin
         wptr <= push ? wptr + 1'b1 : wptr;
         rptr <= pop ? rptr + 1'b1 : rptr;
         count <= (push & ~pop) ? count + 1'b1 : (pop & ~push) ? count - 1'b1 : count;
         data_out <= pop ? rdata : data_out;
         valid_out <= pop;
      end
`ifdef FIFO_ERR_FLAGS_EN
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         err_overflow <= RST_ERR;
         err_underflow <= RST_ERR;
      end else begin
         err_overflow <= err_overflow | (wr_en & full & ~pop);
         err_underflow <= err_underflow | (rd_en & continuar & empty);
      end
`else
   assign err_overflow = 1'b0;
   assign err_underflow = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_umbrales.sv
// tb_fifo_umbrales: directed self-checking bench for fifo_umbrales (DEPTH=8, af=6, ae=2).
module tb_fifo_umbrales;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       wr_en = 1'b0, rd_en = 1'b0, continuar = 1'b1;
   logic [9:0] data_in = '0;
   logic [3:0] umbral_af = 4'd6, umbral_ae = 4'd2;
   logic [9:0] data_out;
   logic       valid_out, full, almost_full, empty, almost_empty;
   logic [3:0] count;
   logic       err_overflow, err_underflow;
   int         checks = 0, fails = 0;
`ifdef FIFO_ERR_FLAGS_EN
   localparam logic ERR_ON = 1'b1;
`else
   localparam logic ERR_ON = 1'b0;
`endif

   fifo_umbrales dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .continuar(continuar), .umbral_af(umbral_af), .umbral_ae(umbral_ae),
      .data_out(data_out), .valid_out(valid_out), .full(full), .almost_full(almost_full),
      .empty(empty), .almost_empty(almost_empty), .count(count),
      .err_overflow(err_overflow), .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   task automatic step(input logic w, input logic r, input logic c, input logic [9:0] d);
      wr_en = w; rd_en = r; continuar = c; data_in = d;
      @(posedge clk);
      #1;
      wr_en = 1'b0; rd_en = 1'b0; continuar = 1'b1;
   endtask

   task automatic test_reset;
      #3;
      checks++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
      checks++; if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin fails++; $display("FAIL reset_flags got %b want 1100", {empty, almost_empty, full, almost_full}); end
      checks++; if ({valid_out, err_overflow, err_underflow} !== 3'b000) begin fails++; $display("FAIL reset_out got %b want 000", {valid_out, err_overflow, err_underflow}); end
      checks++; if (data_out !== 10'h000) begin fails++; $display("FAIL reset_data got %h want 000", data_out); end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_fill;
      for (int k = 1; k <= 8; k++) begin
         step(1'b1, 1'b0, 1'b1, 10'(k));
         checks++;
         if ({count, almost_empty, almost_full} !== {4'(k), k <= 2, k >= 6}) begin
            fails++;
            $display("FAIL fill_%0d got count=%0d ae=%b af=%b want count=%0d ae=%b af=%b",
                     k, count, almost_empty, almost_full, k, k <= 2, k >= 6);
         end
      end
      checks++; if ({full, empty} !== 2'b10) begin fails++; $display("FAIL fill_full got full=%b empty=%b want 1 0", full, empty); end
   endtask

   task automatic test_overflow;
      step(1'b1, 1'b0, 1'b1, 10'h0ff);
      checks++; if (count !== 4'd8) begin fails++; $display("FAIL ovf_count got %0d want 8", count); end
      checks++; if (err_overflow !== ERR_ON) begin fails++; $display("FAIL ovf_flag got %b want %b", err_overflow, ERR_ON); end
      checks++; if (err_underflow !== 1'b0) begin fails++; $display("FAIL ovf_uflag got %b want 0", err_underflow); end
   endtask

   task automatic test_drain;
      for (int k = 1; k <= 8; k++) begin
         step(1'b0, 1'b1, 1'b1, 10'h0);
         checks++;
         if ({valid_out, data_out, count} !== {1'b1, 10'(k), 4'(8 - k)}) begin
            fails++;
            $display("FAIL drain_%0d got v=%b d=%h c=%0d want v=1 d=%h c=%0d", k, valid_out, data_out, count, k, 8 - k);
         end
      end
      checks++; if (empty !== 1'b1) begin fails++; $display("FAIL drain_empty got %b want 1", empty); end
      step(1'b0, 1'b0, 1'b1, 10'h0);
      checks++; if ({valid_out, data_out} !== {1'b0, 10'h008}) begin fails++; $display("FAIL drain_hold got v=%b d=%h want v=0 d=008", valid_out, data_out); end
      step(1'b0, 1'b1, 1'b1, 10'h0);
      checks++; if ({valid_out, count} !== {1'b0, 4'd0}) begin fails++; $display("FAIL uflow_count got v=%b c=%0d want v=0 c=0", valid_out, count); end
      checks++; if (err_underflow !== ERR_ON) begin fails++; $display("FAIL uflow_flag got %b want %b", err_underflow, ERR_ON); end
   endtask

   task automatic test_pause;
      for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b1, 10'h010 + 10'(k));
      step(1'b0, 1'b1, 1'b0, 10'h0);
      checks++; if ({count, valid_out} !== {4'd4, 1'b0}) begin fails++; $display("FAIL pause got c=%0d v=%b want c=4 v=0", count, valid_out); end
      step(1'b0, 1'b1, 1'b1, 10'h0);
      checks++; if ({count, valid_out, data_out} !== {4'd3, 1'b1, 10'h010}) begin fails++; $display("FAIL resume got c=%0d v=%b d=%h want c=3 v=1 d=010", count, valid_out, data_out); end
      for (int k = 1; k < 4; k++) begin
         step(1'b0, 1'b1, 1'b1, 10'h0);
         checks++; if (data_out !== 10'h010 + 10'(k)) begin fails++; $display("FAIL pause_drain_%0d got %h want %h", k, data_out, 10'h010 + 10'(k)); end
      end
   endtask

   task automatic test_back_to_back;
      logic [9:0] q[$];
      logic [1:0] ops [20] = '{2'b11, 2'b10, 2'b01, 2'b01, 2'b11, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10,
                               2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11};
      logic [9:0] last;
      logic [9:0] d;
      logic       pop_ok, push_ok;
      step(1'b1, 1'b1, 1'b1, 10'h020);
      checks++; if ({count, valid_out} !== {4'd1, 1'b0}) begin fails++; $display("FAIL simul_empty got c=%0d v=%b want c=1 v=0", count, valid_out); end
      q.push_back(10'h020);
      for (int k = 1; k < 8; k++) begin
         step(1'b1, 1'b0, 1'b1, 10'h020 + 10'(k));
         q.push_back(10'h020 + 10'(k));
      end
      step(1'b1, 1'b1, 1'b1, 10'h028);
      last = q.pop_front();
      q.push_back(10'h028);
      checks++; if ({count, valid_out, data_out} !== {4'd8, 1'b1, last}) begin fails++; $display("FAIL simul_full got c=%0d v=%b d=%h want c=8 v=1 d=%h", count, valid_out, data_out, last); end
      for (int i = 0; i < 20; i++) begin
         d = 10'h100 + 10'(i);
         pop_ok = ops[i][0] && q.size() > 0;
         push_ok = ops[i][1] && (q.size() < 8 || pop_ok);
         if (pop_ok) last = q.pop_front();
         if (push_ok) q.push_back(d);
         step(ops[i][1], ops[i][0], 1'b1, d);
         checks++;
         if ({count, valid_out, data_out} !== {4'(q.size()), pop_ok, last}) begin
            fails++;
            $display("FAIL mix_%0d got c=%0d v=%b d=%h want c=%0d v=%b d=%h", i, count, valid_out, data_out, q.size(), pop_ok, last);
         end
      end
      while (q.size() > 0) begin
         last = q.pop_front();
         step(1'b0, 1'b1, 1'b1, 10'h0);
         checks++; if (data_out !== last) begin fails++; $display("FAIL mix_drain got %h want %h", data_out, last); end
      end
   endtask

   task automatic test_async_reset;
      for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b1, 10'h200 + 10'(k));
      step(1'b0, 1'b1, 1'b1, 10'h0);
      checks++; if ({count, valid_out, almost_full} !== {4'd5, 1'b1, 1'b0}) begin fails++; $display("FAIL pre_reset got c=%0d v=%b af=%b want c=5 v=1 af=0", count, valid_out, almost_full); end
      umbral_af = 4'd5; umbral_ae = 4'd5;
      #1;
      checks++; if ({almost_full, almost_empty} !== 2'b11) begin fails++; $display("FAIL thresh got af=%b ae=%b want 1 1", almost_full, almost_empty); end
      umbral_af = 4'd6; umbral_ae = 4'd2;
      #1;
      checks++; if ({almost_full, almost_empty, count} !== {2'b00, 4'd5}) begin fails++; $display("FAIL thresh_back got af=%b ae=%b c=%0d want 0 0 5", almost_full, almost_empty, count); end
      reset = 1'b0;
      #1;
      checks++; if ({count, empty, almost_empty, valid_out} !== {4'd0, 3'b110}) begin fails++; $display("FAIL async_reset got c=%0d e=%b ae=%b v=%b want c=0 e=1 ae=1 v=0", count, empty, almost_empty, valid_out); end
      checks++; if ({err_overflow, err_underflow} !== 2'b00) begin fails++; $display("FAIL reset_err got %b want 00", {err_overflow, err_underflow}); end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      step(1'b0, 1'b1, 1'b1, 10'h0);
      checks++; if ({count, empty, almost_empty, valid_out} !== {4'd0, 3'b110}) begin fails++; $display("FAIL post_reset got c=%0d e=%b ae=%b v=%b want c=0 e=1 ae=1 v=0", count, empty, almost_empty, valid_out); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_overflow();
      test_drain();
      test_pause();
      test_back_to_back();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
